// File: rtl/fifo_wm_stat.sv
// Sticky overflow/underflow error flags and high-water-mark register for fifo_wm.
// Latency: flags and hwm update on the clock edge after the triggering cycle.
// Backpressure: none; it observes the FIFO every cycle and never stalls it.
module fifo_wm_stat #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_drop,
   input  logic             pop_empty,
   input  logic [CNT_W-1:0] usage_next,
   input  logic             stat_clr,
   output logic             ovf,
   output logic             udf,
   output logic [CNT_W-1:0] hwm
);

   logic [CNT_W-1:0] hwm_next;

   // A clear reloads the mark from the upcoming fill level instead of zero,
   // so the mark never reads below the level the FIFO actually holds.
   always_comb begin
      hwm_next = hwm;
      if (stat_clr) begin
         hwm_next = usage_next;
      end else if (usage_next > hwm) begin
         hwm_next = usage_next;
      end
   end

   // Sticky flags: a new error in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
         udf <= 1'b0;
         hwm <= '0;
      end else begin
         ovf <= (ovf & ~stat_clr) | push_drop;
         udf <= (udf & ~stat_clr) | pop_empty;
         hwm <= hwm_next;
      end
   end

endmodule

// File: rtl/fifo_wm.sv
// Synchronous FIFO with programmable almost-full/almost-empty watermarks and error/statistics state.
// Latency: push to head in one cycle; zero cycles with FALL_THROUGH when the FIFO is empty.
// Backpressure: pushes while full are dropped (ovf_o); pops while empty are ignored (udf_o).
module fifo_wm #(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 8,
   parameter type         dtype        = logic [DATA_WIDTH-1:0],
   // Derived; exported so instantiators can size thresholds and counts.
   parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             testmode_i,
   input  logic [CNT_W-1:0] alm_full_th_i,
   input  logic [CNT_W-1:0] alm_empty_th_i,
   input  dtype             data_i,
   input  logic             push_i,
   output dtype             data_o,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] usage_o,
   output logic             alm_full_o,
   output logic             alm_empty_o,
   output logic             ovf_o,
   output logic             udf_o,
   output logic [CNT_W-1:0] hwm_o,
   input  logic             stat_clr_i
);

   // A single-entry FIFO still needs a (constant-zero) pointer bit.
   localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

   if (DEPTH < 1) begin : g_depth_chk
      $error("fifo_wm: DEPTH must be at least 1");
   end

   dtype             mem [DEPTH];
   logic [PTR_W-1:0] rptr;
   logic [PTR_W-1:0] wptr;
   logic [CNT_W-1:0] usage;
   logic [CNT_W-1:0] usage_next;
   logic             full;
   logic             empty;
   logic             bypass;
   logic             push_ok;
   logic             pop_ok;
   logic             push_drop;
   logic             pop_empty;

   // The clock-gate bypass has no functional effect inside this block.
   logic unused_testmode;
   assign unused_testmode = testmode_i;

   // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign full  = (usage == DEPTH_CNT);
   assign empty = (usage == '0);

   // Fall-through hand-off: the entry passes straight from data_i to the
   // consumer and never touches storage, pointers or the count.
   assign bypass = FALL_THROUGH && empty && push_i && pop_i && !flush_i;

   // Flush swallows any push/pop issued alongside it, without error.
   assign push_ok   = push_i && !full  && !flush_i && !bypass;
   assign pop_ok    = pop_i  && !empty && !flush_i;
   assign push_drop = push_i && full   && !flush_i;
   assign pop_empty = pop_i  && empty  && !flush_i && !bypass;

   // Count is tracked incrementally; pointer difference is ambiguous when full.
   always_comb begin
      usage_next = usage;
      if (flush_i) begin
         usage_next = '0;
      end else if (push_ok && !pop_ok) begin
         usage_next = usage + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
         usage_next = usage - CNT_W'(1);
      end
   end

   // Pointer and count state; flush returns both pointers to entry 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rptr  <= '0;
         wptr  <= '0;
         usage <= '0;
      end else begin
         usage <= usage_next;
         if (flush_i) begin
            rptr <= '0;
            wptr <= '0;
         end else begin
            if (push_ok) wptr <= ptr_inc(wptr);
            if (pop_ok)  rptr <= ptr_inc(rptr);
         end
      end
   end

   // Storage is not reset; the head is only meaningful while non-empty.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem[wptr] <= data_i;
      end
   end

   assign data_o = (FALL_THROUGH && empty) ? data_i : mem[rptr];

   fifo_wm_stat #(
      .CNT_W      (CNT_W)
   ) u_stat (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .push_drop  (push_drop),
      .pop_empty  (pop_empty),
      .usage_next (usage_next),
      .stat_clr   (stat_clr_i),
      .ovf        (ovf_o),
      .udf        (udf_o),
      .hwm        (hwm_o)
   );

   assign full_o      = full;
   assign empty_o     = empty;
   assign usage_o     = usage;
   assign alm_full_o  = (usage >= alm_full_th_i);
   assign alm_empty_o = (usage <= alm_empty_th_i);

   // A dropped push must not advance the write pointer.
   a_no_wptr_move_on_drop : assert property (
      @(posedge clk_i) disable iff (!rst_ni) push_drop |=> $stable(wptr));

   // A pop on empty must not advance the read pointer.
   a_no_rptr_move_on_udf : assert property (
      @(posedge clk_i) disable iff (!rst_ni) pop_empty |=> $stable(rptr));

   // The fill count can never exceed the capacity.
   a_usage_in_range : assert property (
      @(posedge clk_i) disable iff (!rst_ni) usage <= DEPTH_CNT);

endmodule
